orb_group_writer: RTL and testbench
===================================

// Module: orb_group_writer
// PURPOSE
//  Packs the serial bit stream held in the 1-bit bit FIFO into WORD_BITS-wide words and writes them
//  sequentially into whichever ping-pong group buffer is currently the write page (selected
//  externally by the frame former's swch). Sits between the bit FIFO and the group buffers, clk240 domain.
//  Restarts at address 0 on every page swap; flags pages that were not completely filled.
// PARAMETERS
//  WORD_BITS   12    bits per group-buffer word
//  ADDR_W      10    group-buffer address width
//  PAGE_WORDS  1024  words per page (last address = PAGE_WORDS-1)
//  USED_W      15    width of bit FIFO fill count
// PORTS
//  clk240     in   1          240 MHz clock; all state on rising edge
//  rst        in   1          asynchronous, active-low reset
//  bit_q      in   1          bit FIFO output (normal mode: valid 1 cycle after rdreq)
//  bit_used   in   USED_W     bit FIFO fill level
//  bit_rdreq  out  1          bit FIFO read request
//  swch       in   1          page select from frame-former clock domain (asynchronous here)
//  wr_data    out  WORD_BITS  word to group buffer
//  wr_addr    out  ADDR_W     group-buffer write address
//  wr_en      out  1          one-cycle write strobe
//  page_full  out  1          current write page completely filled
//  underrun   out  1          one-cycle pulse: swap arrived before page was full
// BEHAVIOUR
//  Reset: all outputs 0, addr 0, state WAIT, swap_pend 0, sync regs 0 (sync chain seeded from 0).
//  swch: 2-FF synchroniser + edge register; any toggle = swap event, latched into swap_pend.
//  States:
//   WAIT : if swap_pend -> apply swap (below), stay WAIT. Else if bit_used >= WORD_BITS -> READ, cnt=0.
//   READ : bit_rdreq=1 for exactly WORD_BITS consecutive cycles; shift_reg <= {shift_reg, bit_q}
//          on each of the WORD_BITS cycles following the first rdreq. First bit read = MSB.
//          After last rdreq -> CAPT (one cycle capturing final bit) -> WRITE.
//   WRITE: wr_en=1 one cycle, wr_data=shift_reg. If swap_pend: apply swap first, write at address 0,
//          next addr=1. Else write at addr; if addr==PAGE_WORDS-1 -> page_full=1, HOLD; else addr+1, WAIT.
//   HOLD : no FIFO reads. On swap_pend -> apply swap, WAIT.
//  Apply swap: addr<=0, page_full<=0, swap_pend<=0; underrun pulses 1 cycle iff page_full was 0.
//  Latency: first rdreq to wr_en = WORD_BITS+1 cycles; next word may start the cycle after WRITE.
//  Swap during READ/CAPT: word completes, is written to address 0 of the new page (no bits dropped).
//  Swap and page-full write in same cycle: swap wins; word goes to addr 0 of new page, page_full stays 0,
//  underrun pulses.
//  Two toggles before service: single swap applied (swap_pend is a flag, not a count).
//  bit_used < WORD_BITS: no reads, no partial words; FIFO overflow is handled upstream.
//  wr_addr/wr_data/wr_en registered; wr_addr and wr_data stable only while wr_en=1.
//  Reset mid-word: partial word discarded, no write issued; FIFO bits already read are lost.
// TESTING
//  1. bit_used=12, bits 1,0,1,... MSB first -> 12 rdreq pulses, wr_en once, wr_data=12'hAAA, wr_addr=0.
//  2. Continuous supply, no swap -> 1024 writes at addr 0..1023, then page_full=1, rdreq stays 0.
//  3. From test 2, toggle swch -> ~3 cycles later page_full=0, no underrun, next word at addr 0.
//  4. Toggle swch after 5 words -> underrun one-cycle pulse, next word at addr 0.
//  5. Toggle swch during READ of word 7 -> that word written at addr 0, following word at addr 1.
//  6. Assert rst during READ -> all outputs 0 immediately; after release first write is at addr 0.

Source files
------------

// File: rtl/orb_group_writer.sv
// Packs the serial bit FIFO stream into WORD_BITS-wide words and writes them into the current
// ping-pong group-buffer page, restarting at address 0 on each page swap from the frame former.
`timescale 1ns/1ps
module orb_group_writer #(
  parameter int WORD_BITS  = 12,
  parameter int ADDR_W     = 10,
  parameter int PAGE_WORDS = 1024,
  parameter int USED_W     = 15
) (
  input  logic                 clk240,
  input  logic                 rst,
  input  logic                 bit_q,
  input  logic [USED_W-1:0]    bit_used,
  output logic                 bit_rdreq,
  input  logic                 swch,
  output logic [WORD_BITS-1:0] wr_data,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic                 wr_en,
  output logic                 page_full,
  output logic                 underrun
);

  localparam int                CNT_W     = $clog2(WORD_BITS);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WORD_BITS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PAGE_WORDS - 1);
  localparam logic [USED_W-1:0] WORD_USED = USED_W'(WORD_BITS);

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_READ  = 3'd1,
    S_CAPT  = 3'd2,
    S_WRITE = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [ADDR_W-1:0]      r_addr;
  logic [WORD_BITS-2:0]   r_shift;
  logic                   r_rdreq;
  logic [WORD_BITS-1:0]   r_wr_data;
  logic [ADDR_W-1:0]      r_wr_addr;
  logic                   r_wr_en;
  logic                   r_page_full;
  logic                   r_underrun;
  logic                   r_swap_pend;
  logic                   r_swch_s1;
  logic                   r_swch_s2;
  logic                   r_swch_s3;

  logic                   w_swap_evt;
  logic                   w_apply;
  logic [WORD_BITS-1:0]   w_word;

  // swch crosses from the frame-former domain; any level change is a swap request
  assign w_swap_evt = r_swch_s2 ^ r_swch_s3;

  // The states where a pending swap is consumed; CAPT consumes it so the finishing word lands at 0
  assign w_apply = r_swap_pend &&
                   (r_state == S_WAIT || r_state == S_HOLD || r_state == S_CAPT);

  assign w_word = {r_shift, bit_q};

  // Bits arrive one cycle after each rdreq; the last bit is taken straight from bit_q in CAPT
  always_ff @(posedge clk240) begin
    if (r_state == S_READ && r_cnt != '0) begin
      r_shift <= {r_shift[WORD_BITS-3:0], bit_q};
    end
  end

  always_ff @(posedge clk240 or negedge rst) begin
    if (!rst) begin
      r_state     <= S_WAIT;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_rdreq     <= 1'b0;
      r_wr_data   <= '0;
      r_wr_addr   <= '0;
      r_wr_en     <= 1'b0;
      r_page_full <= 1'b0;
      r_underrun  <= 1'b0;
      r_swap_pend <= 1'b0;
      r_swch_s1   <= 1'b0;
      r_swch_s2   <= 1'b0;
      r_swch_s3   <= 1'b0;
    end else begin
      r_swch_s1   <= swch;
      r_swch_s2   <= r_swch_s1;
      r_swch_s3   <= r_swch_s2;
      r_wr_en     <= 1'b0;
      r_underrun  <= 1'b0;
      r_swap_pend <= w_swap_evt | (r_swap_pend & ~w_apply);

      if (w_apply) begin
        r_page_full <= 1'b0;
        r_underrun  <= ~r_page_full;
      end

      case (r_state)
        S_WAIT: begin
          if (r_swap_pend) begin
            r_addr <= '0;
          end else if (bit_used >= WORD_USED) begin
            r_state <= S_READ;
            r_cnt   <= '0;
            r_rdreq <= 1'b1;
          end
        end

        S_READ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_rdreq <= 1'b0;
            r_state <= S_CAPT;
          end
        end

        S_CAPT: begin
          r_wr_en   <= 1'b1;
          r_wr_data <= w_word;
          r_state   <= S_WRITE;
          if (r_swap_pend) begin
            r_wr_addr <= '0;
            r_addr    <= ADDR_W'(1);
          end else begin
            r_wr_addr <= r_addr;
            if (r_addr == LAST_ADDR) begin
              r_page_full <= 1'b1;
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
        end

        S_WRITE: begin
          r_state <= r_page_full ? S_HOLD : S_WAIT;
        end

        S_HOLD: begin
          if (r_swap_pend) begin
            r_addr  <= '0;
            r_state <= S_WAIT;
          end
        end

        default: r_state <= S_WAIT;
      endcase
    end
  end

  assign bit_rdreq = r_rdreq;
  assign wr_data   = r_wr_data;
  assign wr_addr   = r_wr_addr;
  assign wr_en     = r_wr_en;
  assign page_full = r_page_full;
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_orb_group_writer.sv
// Bench for orb_group_writer: a bit-FIFO model feeds words MSB first, and a word/page-level
// model predicts every write's data, address and page_full plus the running underrun count.
`timescale 1ns/1ps
module tb_orb_group_writer;
  localparam int WB = 12;
  localparam int AW = 10;
  localparam int PW = 1024;
  localparam int UW = 15;

  logic          clk240 = 1'b0;
  logic          rst = 1'b0;
  logic          bit_q = 1'b0;
  logic [UW-1:0] bit_used = '0;
  logic          swch = 1'b0;
  logic          bit_rdreq;
  logic [WB-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic          page_full;
  logic          underrun;

  orb_group_writer #(.WORD_BITS(WB), .ADDR_W(AW), .PAGE_WORDS(PW), .USED_W(UW)) dut (
    .clk240   (clk240),
    .rst      (rst),
    .bit_q    (bit_q),
    .bit_used (bit_used),
    .bit_rdreq(bit_rdreq),
    .swch     (swch),
    .wr_data  (wr_data),
    .wr_addr  (wr_addr),
    .wr_en    (wr_en),
    .page_full(page_full),
    .underrun (underrun)
  );

  always #2 clk240 = ~clk240;

  int checks = 0;
  int errors = 0;

  bit            fifo[$];
  logic [WB-1:0] exp_words[$];
  logic [AW-1:0] wr_addrs[$];
  int            model_addr = 0;
  bit            model_full = 1'b0;
  int            exp_ur = 0;
  int            wr_count = 0;
  int            ur_count = 0;
  int            rd_count = 0;
  int            cyc = 0;
  int            first_rd_cyc = -1;
  int            first_wr_cyc = -1;
  logic [AW-1:0] last_addr = '0;
  logic [WB-1:0] last_data = '0;
  bit            prev_ur = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk240);
  endtask

  task automatic push_word(input logic [WB-1:0] w);
    for (int i = WB - 1; i >= 0; i--) fifo.push_back(w[i]);
    exp_words.push_back(w);
  endtask

  task automatic wait_writes(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (wr_count < target && n < budget) begin
      @(negedge clk240);
      n++;
    end
    if (wr_count < target) chk({name, "_timeout"}, wr_count, target);
  endtask

  task automatic wait_rdreq(input int budget, input string name);
    int n;
    n = 0;
    while (!bit_rdreq && n < budget) begin
      @(negedge clk240);
      n++;
    end
    if (!bit_rdreq) chk({name, "_rdreq_timeout"}, 0, 1);
  endtask

  // A counted toggle is a real swap: the next word starts a fresh page
  task automatic toggle(input bit counted);
    swch = ~swch;
    if (counted) begin
      if (!model_full) exp_ur++;
      model_addr = 0;
      model_full = 1'b0;
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_rdreq"}, bit_rdreq, 0);
    chk({tag, "_page_full"}, page_full, 0);
    chk({tag, "_underrun"}, underrun, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
  endtask

  // Bit FIFO in normal mode: data appears one cycle after the rdreq the DUT registered
  initial begin
    bit rd_s;
    forever begin
      @(negedge clk240);
      rd_s = bit_rdreq;
      @(posedge clk240);
      #1;
      if (rd_s && rst) begin
        if (fifo.size() > 0) bit_q = fifo.pop_front();
        else chk("fifo_underflow_read", 1, 0);
      end
      bit_used = UW'(fifo.size());
    end
  end

  initial begin
    forever begin
      @(negedge clk240);
      cyc++;
      if (rst) begin
        if (bit_rdreq) begin
          rd_count++;
          if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        if (underrun) begin
          ur_count++;
          chk("underrun_width", prev_ur, 0);
        end
        prev_ur = underrun;
        if (wr_en) begin
          wr_count++;
          if (first_wr_cyc < 0) first_wr_cyc = cyc;
          last_addr = wr_addr;
          last_data = wr_data;
          wr_addrs.push_back(wr_addr);
          if (exp_words.size() == 0) chk("unexpected_write", 1, 0);
          else chk("wr_data", wr_data, exp_words.pop_front());
          chk("wr_addr", wr_addr, model_addr);
          model_addr++;
          if (model_addr == PW) begin
            model_full = 1'b1;
            model_addr = PW - 1;
          end
          chk("page_full", page_full, model_full);
        end
      end else begin
        prev_ur = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_snap;
    int w_snap;

    tick(3);
    chk_outputs_zero("reset");
    rst = 1'b1;
    tick(3);

    // Single word 1010... MSB first
    push_word(12'hAAA);
    wait_writes(1, 100, "t1");
    tick(2);
    chk("t1_rdreq_pulses", rd_count, 12);
    chk("t1_data", last_data, 12'hAAA);
    chk("t1_addr", last_addr, 0);
    chk("t1_latency", first_wr_cyc - first_rd_cyc, WB + 1);

    // Fill the rest of the page
    for (int i = 1; i < PW; i++) push_word(WB'(i * 37) ^ 12'h5A5);
    wait_writes(PW, 30000, "t2");
    tick(5);
    chk("t2_full", page_full, 1);
    chk("t2_count", wr_count, PW);
    chk("t2_last_addr", last_addr, PW - 1);
    rd_snap = rd_count;
    push_word(12'h123);
    tick(40);
    chk("t2_hold_no_read", rd_count, rd_snap);
    chk("t2_hold_no_write", wr_count, PW);

    // Swap from a full page
    toggle(1'b1);
    tick(6);
    chk("t3_full_cleared", page_full, 0);
    chk("t3_no_underrun", ur_count, 0);
    wait_writes(PW + 1, 100, "t3");
    chk("t3_addr", last_addr, 0);
    chk("t3_data", last_data, 12'h123);

    // Swap after five words of a page
    for (int i = 0; i < 4; i++) push_word(12'h100 + WB'(i));
    wait_writes(PW + 5, 200, "t4a");
    toggle(1'b1);
    tick(8);
    chk("t4_underrun", ur_count, 1);
    chk("t4_underrun_model", ur_count, exp_ur);
    chk("t4_full", page_full, 0);
    push_word(12'h0F0);
    wait_writes(PW + 6, 100, "t4b");
    chk("t4_addr", last_addr, 0);

    // Swap during the read of word 7
    for (int i = 0; i < 5; i++) push_word(12'h200 + WB'(i));
    wait_writes(PW + 11, 300, "t5a");
    push_word(12'h777);
    wait_rdreq(50, "t5");
    tick(2);
    toggle(1'b1);
    push_word(12'h888);
    wait_writes(PW + 13, 200, "t5b");
    chk("t5_word7_addr", wr_addrs[PW + 11], 0);
    chk("t5_next_addr", wr_addrs[PW + 12], 1);
    chk("t5_underrun", ur_count, 2);

    // Two toggles before the swap is serviced count as one swap
    push_word(12'h3C3);
    wait_rdreq(50, "t5d");
    tick(1);
    toggle(1'b1);
    tick(3);
    toggle(1'b0);
    wait_writes(PW + 14, 100, "t5c");
    push_word(12'hC3C);
    wait_writes(PW + 15, 100, "t5e");
    chk("t5_dbl_first_addr", wr_addrs[PW + 13], 0);
    chk("t5_dbl_second_addr", wr_addrs[PW + 14], 1);
    chk("t5_dbl_underrun", ur_count, 3);
    chk("t5_dbl_underrun_model", ur_count, exp_ur);

    // Reset in the middle of a word
    push_word(12'hFFF);
    wait_rdreq(50, "t6");
    tick(4);
    #1;
    rst = 1'b0;
    #1;
    chk_outputs_zero("t6_reset");
    fifo.delete();
    exp_words.delete();
    model_addr = 0;
    model_full = 1'b0;
    w_snap = wr_count;
    tick(3);
    rst = 1'b1;
    // The synchroniser restarts from 0, so a high swch reads as one more swap on an empty page
    if (swch) exp_ur++;
    tick(10);
    chk("t6_no_write", wr_count, w_snap);
    chk("t6_underrun_model", ur_count, exp_ur);
    push_word(12'h5C3);
    wait_writes(w_snap + 1, 100, "t6");
    chk("t6_addr", last_addr, 0);
    chk("t6_data", last_data, 12'h5C3);
    tick(5);
    chk("final_underruns", ur_count, exp_ur);
    chk("final_pending_words", exp_words.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
